// File: rtl/uart_out_parity.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, then STOP_BITS stop bits.
// The serial line is driven from a flop so it cannot glitch.
module uart_out_parity #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int             BW        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          out_q, out_d;
    logic          bit_done;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        par_d    = par_q;
        bit_done = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_START;
                    shift_d = data;
                    par_d   = (^data) ^ PARITY_ODD;
                    baud_d  = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line value is chosen from the upcoming state so it appears one cycle after the decision.
        case (state_d)
            S_START:  out_d = 1'b0;
            S_DATA:   out_d = shift_d[0];
            S_PARITY: out_d = par_d;
            default:  out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
        end
    end

    // ready is held low while rst is high.
    assign ready     = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out       = out_q;
    assign dbg_state = state_q;

endmodule
